instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Upstream stage of the control unit: owns the program counter, fetches 16-bit instructions from instruction memory over a req/ack handshake, and holds them in an instruction register.
- Splits the held instruction into op/rs/rt/imm fields; op drives the control unit directly.
- Takes the control unit's Jump output back to select the next PC.

Parameters:
- PC_W, 8, program counter / instruction memory address width; legal range 2..13.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  PC_W  fetch address; equals pc.
- imem_rdata  in  16  instruction word; valid when imem_ack=1.
- imem_ack  in  1  memory completes the request this cycle.
- stall  in  1  downstream not ready; hold the current instruction.
- Jump  in  1  from control unit; next PC is the jump target.
- instr_valid  out  1  op/rs/rt/imm hold a valid instruction.
- op  out  3  instr[15:13]; feeds control unit.
- rs  out  3  instr[12:10].
- rt  out  3  instr[9:7].
- imm  out  7  instr[6:0]; goes to sign extension.
- pc  out  PC_W  address of the instruction currently held or being fetched.

Behaviour:
- Reset is async on rst_n low. Reset values: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, IR=16'h0000 (op=000 is a NOP: no case in control unit, no register write, no jump), rs=rt=imm=0. FSM goes to IDLE.
- FSM states: IDLE, REQ, VALID. All outputs are registered or decoded from registered state/IR.
- IDLE: exists for one cycle only, the first clock after rst_n rises. imem_req=0. Next state is REQ.
- REQ:
  - imem_req=1; imem_addr=pc, held stable until ack.
  - On imem_ack=1: IR <= imem_rdata; next state VALID.
  - On imem_ack=0: stay in REQ, with no limit on wait cycles.
- VALID:
  - instr_valid=1; imem_req=0; op/rs/rt/imm reflect IR.
  - stall=1: hold everything (IR, pc, state). Jump is ignored.
  - stall=0: the instruction is consumed this cycle. Next state is REQ.
  - Next pc: if Jump=1, next pc = IR[12:0] truncated to PC_W; else pc+1, wrapping modulo 2^PC_W (all-ones -> 0).
- Throughput: with zero-wait memory (ack in the first REQ cycle), one instruction per 2 cycles. Each memory wait cycle adds 1.
- Jump is sampled only in VALID with stall=0. Jump in any other state is ignored.
- imem_ack outside REQ is ignored; IR is unchanged.
- Reset mid-REQ: imem_req drops asynchronously, and any in-flight ack is discarded. After release, the fetch restarts at RESET_PC via IDLE.
- Reset mid-VALID: instr_valid clears immediately and IR clears to 0.
- Jump target equal to the current pc (self-loop) is legal: the same address is refetched.

Optional Feature:
- Macro: INSTR_FETCH_COUNT_EN.
- When defined:
  - Adds output port fetch_count [15:0].
  - Resets to 0; increments by 1 on each instruction consumed (VALID and stall=0).
  - Wraps 16'hFFFF -> 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants OP_LW=3'b001, OP_SW=3'b010, OP_JMP=3'b011, OP_ADD=3'b100, OP_ADDI=3'b101, OP_SUB=3'b110, OP_NOP=3'b000;
  - instruction field bit positions (OP_HI=15, OP_LO=13, RS_HI=12, RT_HI=9, IMM_HI=6);
  - INSTR_W=16;
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, VALID=2'd2).
- One sub-module, pc_next: a combinational next-PC mux (pc+1 vs. truncated jump target) with PC_W parameter. The FSM and IR stay in instr_fetch.

Test Plan:
- Reset then zero-wait memory returning 16'h8000+addr: requests go out at pc=0,1,2,3. op=100 at each VALID; instr_valid pulses 1 every 2nd cycle.
- Memory ack delayed 3 cycles at addr 5: imem_req and imem_addr=5 are held stable for 4 cycles. IR loads only on the ack cycle; no spurious instr_valid.
- IR=16'h6012 (op=011) with Jump=1 and stall=0: next imem_addr=8'h12. Same instruction with stall=1 for 4 cycles and then released: the jump is taken only on release, and pc holds until then.
- pc=8'hFF, Jump=0, consumed: next imem_addr=8'h00. Hold stall=1 with Jump toggling: pc, op and rs/rt/imm are unchanged throughout.
- rst_n low while in REQ at pc=7, with ack arriving in the same cycle: imem_req=0 immediately and IR stays 0. After release, 1 IDLE cycle, then a request at addr 0.
- With INSTR_FETCH_COUNT_EN: 10 instructions consumed gives fetch_count=10. Preload near the limit and consume one at 16'hFFFF: fetch_count becomes 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions and the fetch FSM encoding.
package cpu_pkg;
  localparam int INSTR_W = 16;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LW   = 3'b001;
  localparam logic [2:0] OP_SW   = 3'b010;
  localparam logic [2:0] OP_JMP  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_ADDI = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 13;
  localparam int RS_HI  = 12;
  localparam int RT_HI  = 9;
  localparam int IMM_HI = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/pc_next.sv
// Next-PC select: sequential increment (wrapping) or jump target truncated to PC_W.
module pc_next #(
  parameter int PC_W = 8
) (
  input  logic [PC_W-1:0] pc,
  input  logic            jump,
  input  logic [12:0]     target,
  output logic [PC_W-1:0] nxt
);
  assign nxt = jump ? PC_W'(target) : pc + PC_W'(1);
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, req/ack fetch FSM and instruction register with field split.
// Optional INSTR_FETCH_COUNT_EN adds a 16-bit consumed-instruction counter.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  input  logic            imem_ack,
  input  logic            stall,
  input  logic            Jump,
  output logic            instr_valid,
  output logic [2:0]      op,
  output logic [2:0]      rs,
  output logic [2:0]      rt,
  output logic [6:0]      imm,
  output logic [PC_W-1:0] pc
`ifdef INSTR_FETCH_COUNT_EN
  ,
  output logic [15:0]     fetch_count
`endif
);
  fetch_state_t         state;
  logic [INSTR_W-1:0]   ir;
  logic [PC_W-1:0]      pc_nxt;
  logic                 consume;

  pc_next #(.PC_W(PC_W)) u_pc_next (
    .pc     (pc),
    .jump   (Jump),
    .target (ir[RS_HI:0]),
    .nxt    (pc_nxt)
  );

  assign consume   = (state == VALID) && !stall;
  assign imem_addr = pc;
  assign op        = ir[OP_HI:OP_LO];
  assign rs        = ir[RS_HI -: 3];
  assign rt        = ir[RT_HI -: 3];
  assign imm       = ir[IMM_HI:0];

  // Outputs are registered alongside the state so they change only on state transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      ir          <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          imem_req <= 1'b1;
          state    <= REQ;
        end
        REQ: begin
          if (imem_ack) begin
            ir          <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= VALID;
          end
        end
        VALID: begin
          if (consume) begin
            pc          <= pc_nxt;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= REQ;
          end
        end
        default: begin
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

`ifdef INSTR_FETCH_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       fetch_count <= '0;
    else if (consume) fetch_count <= fetch_count + 16'd1;
  end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: zero-wait and delayed fetches, jumps, stalls, wrap and resets.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic        stall = 1'b0;
  logic        Jump = 1'b0;
  logic        instr_valid;
  logic [2:0]  op, rs, rt;
  logic [6:0]  imm;
  logic [7:0]  pc;
`ifdef INSTR_FETCH_COUNT_EN
  logic [15:0] fetch_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .stall       (stall),
    .Jump        (Jump),
    .instr_valid (instr_valid),
    .op          (op),
    .rs          (rs),
    .rt          (rt),
    .imm         (imm),
    .pc          (pc)
`ifdef INSTR_FETCH_COUNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_ir", {16'h0, op, rs, rt, imm}, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_req", 32'(imem_req), 0);
    tick();
    chk("first_req", 32'(imem_req), 1);

    // Zero-wait memory returning 16'h8000+addr
    for (int i = 0; i < 4; i++) begin
      chk("zw_addr", 32'(imem_addr), 32'(i));
      chk("zw_req", 32'(imem_req), 1);
      chk("zw_novalid", 32'(instr_valid), 0);
      imem_ack = 1'b1;
      imem_rdata = 16'h8000 + 16'(i);
      tick();
      imem_ack = 1'b0;
      chk("zw_valid", 32'(instr_valid), 1);
      chk("zw_op", 32'(op), 32'h4);
      chk("zw_imm", 32'(imm), 32'(i));
      chk("zw_req_low", 32'(imem_req), 0);
      tick();
    end

    // Fetch at 4, then 3 wait cycles at 5
    chk("a4_addr", 32'(imem_addr), 4);
    imem_ack = 1'b1;
    imem_rdata = 16'h8004;
    tick();
    imem_ack = 1'b0;
    imem_rdata = 16'h1234;
    tick();
    chk("w_addr0", 32'(imem_addr), 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("w_req", 32'(imem_req), 1);
      chk("w_addr", 32'(imem_addr), 5);
      chk("w_novalid", 32'(instr_valid), 0);
      chk("w_ir_hold", 32'(imm), 4);
    end
    imem_ack = 1'b1;
    imem_rdata = 16'h6012;
    tick();
    imem_ack = 1'b0;
    chk("j_op", 32'(op), 32'h3);
    chk("j_imm", 32'(imm), 32'h12);

    // Stall with Jump asserted: nothing moves until release
    stall = 1'b1;
    Jump = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("js_pc", 32'(pc), 5);
      chk("js_valid", 32'(instr_valid), 1);
      chk("js_req", 32'(imem_req), 0);
    end
    stall = 1'b0;
    tick();
    Jump = 1'b0;
    chk("j_addr", 32'(imem_addr), 32'h12);
    chk("j_req", 32'(imem_req), 1);

    // Jump to 0xFF, then sequential wrap with stall and Jump toggling
    imem_ack = 1'b1;
    imem_rdata = 16'h60FF;
    tick();
    imem_ack = 1'b0;
    Jump = 1'b1;
    tick();
    Jump = 1'b0;
    chk("ff_addr", 32'(imem_addr), 32'hFF);
    imem_ack = 1'b1;
    imem_rdata = 16'hAEDA;
    tick();
    imem_rdata = 16'h5555;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Jump = ~Jump;
      tick();
      chk("st_pc", 32'(pc), 32'hFF);
      chk("st_op", 32'(op), 5);
      chk("st_rs", 32'(rs), 3);
      chk("st_rt", 32'(rt), 5);
      chk("st_imm", 32'(imm), 32'h5A);
    end
    imem_ack = 1'b0;
    stall = 1'b0;
    Jump = 1'b0;
    tick();
    chk("wrap_addr", 32'(imem_addr), 0);

    // Move to pc=7, then reset mid-REQ with an ack in flight
    imem_ack = 1'b1;
    imem_rdata = 16'h6007;
    tick();
    imem_ack = 1'b0;
    Jump = 1'b1;
    tick();
    Jump = 1'b0;
    chk("p7_addr", 32'(imem_addr), 7);
    imem_ack = 1'b1;
    imem_rdata = 16'h8888;
    rst_n = 1'b0;
    #1;
    chk("rr_req", 32'(imem_req), 0);
    chk("rr_pc", 32'(pc), 0);
    tick();
    chk("rr_ir", {16'h0, op, rs, rt, imm}, 0);
    imem_ack = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rr_idle_done", 32'(imem_req), 1);
    chk("rr_addr", 32'(imem_addr), 0);

    // Reset mid-VALID clears instr_valid and IR immediately
    imem_ack = 1'b1;
    imem_rdata = 16'hC3A5;
    tick();
    imem_ack = 1'b0;
    chk("rv_valid_pre", 32'(instr_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("rv_valid", 32'(instr_valid), 0);
    chk("rv_ir", {16'h0, op, rs, rt, imm}, 0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef INSTR_FETCH_COUNT_EN
    chk("cnt_rst", 32'(fetch_count), 0);
    for (int i = 0; i < 10; i++) begin
      imem_ack = 1'b1;
      imem_rdata = 16'h8000;
      tick();
      imem_ack = 1'b0;
      tick();
    end
    chk("cnt_10", 32'(fetch_count), 10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
